// File: rtl/bus_cycle_ctrl.sv
// rtl/bus_cycle_ctrl.sv - Z80 external bus machine-cycle sequencer (MR/MW, optional PR/PW)
//
// Purpose:
//    Runs one external bus machine cycle per accepted request at T-state
//    granularity (T1, T2, TW*, T3).
//    Wait states are inserted while WAIT_L is low.
//    The bus is handed to an external master (BUSREQ_L/BUSACK_L) only at
//    cycle boundaries.
//    Every pin-level output is decoded from registered state and registered
//    request fields. The one exception is ready, which is the accept
//    handshake and also depends on BUSREQ_L.
//
// Configuration macro:
//    Z80_IO_CYCLE_EN - when defined, req_io selects a port cycle: IORQ_L is
//    used instead of MREQ_L and IO_WAIT_STATES forced TW cycles are inserted.
//    When undefined, req_io is ignored and IORQ_L stays high.
//
// Ports:
//    clk, rst_L                      clock, asynchronous active-low reset
//    req, req_we, req_io             cycle request and its type
//    req_addr, req_wdata             request address / write data, captured on accept
//    ready                           request can be accepted this cycle
//    done, rd_le                     final-T3 pulse, read-data latch strobe
//    addr_out, addr_oe               registered address and its drive enable
//    data_out, data_oe               registered write data and its drive enable
//    WAIT_L                          external wait request
//    MREQ_L, IORQ_L, RD_L, WR_L      bus strobes
//    BUSREQ_L, BUSACK_L              external bus request / grant
module bus_cycle_ctrl #(
   parameter int ADDR_W         = 16,
   parameter int DATA_W         = 8,
   parameter int IO_WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              rst_L,
   input  logic              req,
   input  logic              req_we,
   input  logic              req_io,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              ready,
   output logic              done,
   output logic              rd_le,
   output logic [ADDR_W-1:0] addr_out,
   output logic              addr_oe,
   output logic [DATA_W-1:0] data_out,
   output logic              data_oe,
   input  logic              WAIT_L,
   output logic              MREQ_L,
   output logic              IORQ_L,
   output logic              RD_L,
   output logic              WR_L,
   input  logic              BUSREQ_L,
   output logic              BUSACK_L
);

   localparam int WCNT_W = 8;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_T1    = 3'd1,
      S_T2    = 3'd2,
      S_TW    = 3'd3,
      S_T3    = 3'd4,
      S_BUSAK = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                we_q;
   logic                io_q;
   logic                io_d;
   logic                accept;

   assign accept = req && ready;

`ifdef Z80_IO_CYCLE_EN
   assign io_d = req_io;
`else
   // Port cycles are compiled out: every request runs as a memory cycle.
   logic unused_req_io;
   assign unused_req_io = req_io;
   assign io_d          = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Captured request and forced-wait counter; reset discards an in-flight request
   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         io_q    <= 1'b0;
         wcnt_q  <= '0;
      end else begin
         wcnt_q <= wcnt_d;
         if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            we_q    <= req_we;
            io_q    <= io_d;
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         S_IDLE: begin
            // Bus request has priority over a simultaneous cycle request
            if (!BUSREQ_L) begin
               state_d = S_BUSAK;
            end else if (req) begin
               state_d = S_T1;
            end
         end
         S_T1: begin
            state_d = S_T2;
         end
         S_T2: begin
            if (io_q && (IO_WAIT_STATES > 0)) begin
               state_d = S_TW;
               wcnt_d  = WCNT_W'(IO_WAIT_STATES);
            end else if (WAIT_L) begin
               state_d = S_T3;
            end else begin
               state_d = S_TW;
            end
         end
         S_TW: begin
            // Forced waits run down first; WAIT_L is honoured from the last forced TW on
            if (wcnt_q > WCNT_W'(1)) begin
               wcnt_d = wcnt_q - WCNT_W'(1);
            end else begin
               wcnt_d = '0;
               if (WAIT_L) begin
                  state_d = S_T3;
               end
            end
         end
         S_T3: begin
            if (!BUSREQ_L) begin
               state_d = S_BUSAK;
            end else if (req) begin
               state_d = S_T1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_BUSAK: begin
            if (BUSREQ_L) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode from registered state
   always_comb begin
      ready    = 1'b0;
      done     = 1'b0;
      rd_le    = 1'b0;
      addr_oe  = 1'b0;
      data_oe  = 1'b0;
      MREQ_L   = 1'b1;
      IORQ_L   = 1'b1;
      RD_L     = 1'b1;
      WR_L     = 1'b1;
      BUSACK_L = 1'b1;
      case (state_q)
         S_IDLE: begin
            ready = BUSREQ_L;
         end
         S_T1: begin
            addr_oe = 1'b1;
            // Port cycles hold off IORQ_L and the read strobe until T2
            if (!io_q) begin
               MREQ_L = 1'b0;
               RD_L   = we_q;
            end
         end
         S_T2, S_TW, S_T3: begin
            addr_oe = 1'b1;
            MREQ_L  = io_q;
            IORQ_L  = !io_q;
            RD_L    = we_q;
            WR_L    = !we_q;
            data_oe = we_q;
            if (state_q == S_T3) begin
               done  = 1'b1;
               rd_le = !we_q;
               ready = BUSREQ_L;
            end
         end
         S_BUSAK: begin
            BUSACK_L = 1'b0;
         end
         default: begin
            ready = 1'b0;
         end
      endcase
   end

   assign addr_out = addr_q;
   assign data_out = wdata_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// tb/tb_bus_cycle_ctrl.sv - self-checking bench for bus_cycle_ctrl (memory cycles)
module tb_bus_cycle_ctrl;

   logic        clk = 1'b0;
   logic        rst_L;
   logic        req, req_we, req_io;
   logic [15:0] req_addr;
   logic [7:0]  req_wdata;
   logic        ready, done, rd_le, addr_oe, data_oe;
   logic [15:0] addr_out;
   logic [7:0]  data_out;
   logic        WAIT_L, MREQ_L, IORQ_L, RD_L, WR_L, BUSREQ_L, BUSACK_L;

   bus_cycle_ctrl #(.ADDR_W(16), .DATA_W(8), .IO_WAIT_STATES(1)) dut (
      .clk(clk), .rst_L(rst_L), .req(req), .req_we(req_we), .req_io(req_io),
      .req_addr(req_addr), .req_wdata(req_wdata), .ready(ready), .done(done),
      .rd_le(rd_le), .addr_out(addr_out), .addr_oe(addr_oe), .data_out(data_out),
      .data_oe(data_oe), .WAIT_L(WAIT_L), .MREQ_L(MREQ_L), .IORQ_L(IORQ_L),
      .RD_L(RD_L), .WR_L(WR_L), .BUSREQ_L(BUSREQ_L), .BUSACK_L(BUSACK_L)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [7:0]  wdata;
      int          nwait;
   } txn_t;

   txn_t q[$];
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_quiet(input logic busak, input logic [15:0] a, input logic [7:0] d);
      chk("q_MREQ_L", MREQ_L, 1);
      chk("q_IORQ_L", IORQ_L, 1);
      chk("q_RD_L", RD_L, 1);
      chk("q_WR_L", WR_L, 1);
      chk("q_addr_oe", addr_oe, 0);
      chk("q_data_oe", data_oe, 0);
      chk("q_done", done, 0);
      chk("q_rd_le", rd_le, 0);
      chk("q_BUSACK_L", BUSACK_L, !busak);
      chk("q_addr_out", addr_out, a);
      chk("q_data_out", data_out, d);
   endtask

   task automatic present(input txn_t t);
      req       = 1'b1;
      req_we    = t.we;
      req_addr  = t.addr;
      req_wdata = t.wdata;
      req_io    = 1'($urandom);
   endtask

   // Random request fields while the block must not accept anything
   task automatic drive_noise();
      req       = 1'($urandom);
      req_we    = 1'($urandom);
      req_io    = 1'($urandom);
      req_addr  = 16'($urandom);
      req_wdata = 8'($urandom);
   endtask

   // Model: a cycle with n waits spans 3+n clocks; k=0 is T1, k=last is T3.
   // Starts at a negedge with the DUT idle.
   task automatic run_burst(input bit end_busreq);
      int   last;
      txn_t t;
      BUSREQ_L = 1'b1;
      present(q[0]);
      #1 chk("ready_idle", ready, 1);
      foreach (q[i]) begin
         t    = q[i];
         last = 2 + t.nwait;
         for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            chk("MREQ_L", MREQ_L, 0);
            chk("IORQ_L", IORQ_L, 1);
            chk("RD_L", RD_L, t.we);
            chk("WR_L", WR_L, !(t.we && k >= 1));
            chk("addr_oe", addr_oe, 1);
            chk("addr_out", addr_out, t.addr);
            chk("data_oe", data_oe, t.we && k >= 1);
            chk("data_out", data_out, t.wdata);
            chk("done", done, k == last);
            chk("rd_le", rd_le, (k == last) && !t.we);
            chk("BUSACK_L", BUSACK_L, 1);
            // WAIT_L only matters in T2/TW; elsewhere it is random
            if (k >= 1 && k <= t.nwait + 1) WAIT_L = (k <= t.nwait) ? 1'b0 : 1'b1;
            else                            WAIT_L = 1'($urandom);
            if (k < last) begin
               drive_noise();
               BUSREQ_L = 1'($urandom);
            end else if (i + 1 < q.size()) begin
               present(q[i+1]);
               BUSREQ_L = 1'b1;
            end else begin
               if (end_busreq) drive_noise();
               else            req = 1'b0;
               BUSREQ_L = !end_busreq;
            end
            #1 chk("ready", ready, (k == last) && BUSREQ_L);
         end
      end
   endtask

   task automatic after_burst(input bit end_busreq, input logic [15:0] a, input logic [7:0] d);
      int n;
      if (end_busreq) begin
         n = $urandom_range(1, 3);
         for (int j = 0; j < n; j++) begin
            @(negedge clk);
            check_quiet(1'b1, a, d);
            drive_noise();
            BUSREQ_L = (j == n - 1);
            #1 chk("ready_busak", ready, 0);
         end
      end
      @(negedge clk);
      check_quiet(1'b0, a, d);
      req      = 1'b0;
      BUSREQ_L = 1'b1;
      #1 chk("ready_after", ready, 1);
   endtask

   task automatic burst(input bit end_busreq);
      txn_t tl;
      tl = q[q.size()-1];
      run_burst(end_busreq);
      after_burst(end_busreq, tl.addr, tl.wdata);
      q.delete();
   endtask

   initial begin
      txn_t t;
      int   n;
      rst_L = 1'b0; req = 1'b0; req_we = 1'b0; req_io = 1'b0;
      req_addr = '0; req_wdata = '0; WAIT_L = 1'b1; BUSREQ_L = 1'b1;
      repeat (2) @(negedge clk);
      check_quiet(1'b0, 16'h0000, 8'h00);
      chk("reset_ready", ready, 1);
      rst_L = 1'b1;

      // Read 1234, no waits
      q.push_back('{1'b0, 16'h1234, 8'h00, 0});
      burst(1'b0);
      // Write A5 to 8000 with two waits
      q.push_back('{1'b1, 16'h8000, 8'hA5, 2});
      burst(1'b0);
      // Two back-to-back reads
      q.push_back('{1'b0, 16'h0100, 8'h11, 0});
      q.push_back('{1'b0, 16'h0101, 8'h22, 0});
      burst(1'b0);
      // Bus request during a read, granted after T3
      q.push_back('{1'b0, 16'h2468, 8'h5A, 0});
      burst(1'b1);

      // Bus request in IDLE beats a simultaneous cycle request
      t = '{1'b1, 16'hBEEF, 8'h77, 0};
      present(t);
      BUSREQ_L = 1'b0;
      #1 chk("idle_busreq_ready", ready, 0);
      @(negedge clk);
      check_quiet(1'b1, 16'h2468, 8'h5A);
      req = 1'b0;
      BUSREQ_L = 1'b1;
      @(negedge clk);
      check_quiet(1'b0, 16'h2468, 8'h5A);
      chk("idle_after_busak_ready", ready, 1);

      // Reset in the middle of a wait state
      WAIT_L = 1'b0;
      present('{1'b1, 16'h4321, 8'h3C, 9});
      @(negedge clk); req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("tw_WR_L", WR_L, 0);
      rst_L = 1'b0;
      #1 check_quiet(1'b0, 16'h0000, 8'h00);
      chk("rst_ready", ready, 1);
      @(negedge clk);
      rst_L  = 1'b1;
      WAIT_L = 1'b1;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         check_quiet(1'b0, 16'h0000, 8'h00);
      end

      // Random bursts
      for (int r = 0; r < 25; r++) begin
         n = $urandom_range(1, 3);
         for (int j = 0; j < n; j++) begin
            q.push_back('{1'($urandom), 16'($urandom), 8'($urandom), int'($urandom_range(0, 3))});
         end
         burst(1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
